sfb_boundary_sequencer: RTL and testbench



---
 rtl/sfb_pkg.sv | 44 ++++
 rtl/sfb_boundary_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_sfb_boundary_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfb_pkg.sv
// Shared encodings for the scalefactor-band boundary sequencer: block modes,
// band counts, expected granule totals and the sequencer FSM states.
package sfb_pkg;

  // Block mode as carried in side info.
  typedef enum logic [1:0] {
    MODE_LONG    = 2'b00,
    MODE_SHORT   = 2'b01,
    MODE_MIXED   = 2'b10,
    MODE_ILLEGAL = 2'b11
  } sfb_mode_e;

  // Sample-rate index; only the all-ones code is rejected.
  localparam logic [1:0] FREQ_ILLEGAL = 2'b11;

  // Bands per granule for each block mode.
  localparam int SFB_LONG  = 22;
  localparam int SFB_SHORT = 13;
  localparam int SFB_MIXED = 17;

  // Sum of band widths per granule; the consumer checks these, not us.
  localparam int TOTAL_LONG  = 576;
  localparam int TOTAL_SHORT = 192;
  localparam int TOTAL_MIXED = 576;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } sfb_state_e;

  // Index of the final band for a (legal) block mode.
  function automatic logic [4:0] last_band(input logic [1:0] m);
    case (sfb_mode_e'(m))
      MODE_SHORT: return 5'(SFB_SHORT - 1);
      MODE_MIXED: return 5'(SFB_MIXED - 1);
      default:    return 5'(SFB_LONG - 1);
    endcase
  endfunction

endpackage

// File: rtl/sfb_boundary_sequencer.sv
// Walks the band-width ROM for one granule and streams (index, start, width,
// last) records to the requantizer. One ROM read per band, no prefetch.
//
// Record handshake: sfb_valid rises with a complete, stable payload; the
// record transfers on a rising edge where sfb_valid && sfb_ready. Once raised,
// sfb_valid and the payload hold until that transfer, except on abort,
// accumulator overflow or reset, which withdraw it.
module sfb_boundary_sequencer
  import sfb_pkg::*;
#(
  parameter int ROM_LAT  = 1,
  parameter int IDX_BITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [1:0]          freq,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                rom_en,
  output logic [8:0]          rom_addr,
  input  logic [7:0]          rom_data,
  output logic                sfb_valid,
  input  logic                sfb_ready,
  output logic [4:0]          sfb_index,
  output logic [IDX_BITS-1:0] sfb_start,
  output logic [7:0]          sfb_width,
  output logic                sfb_last,
  output sfb_state_e          dbg_state
);

  localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  sfb_state_e          state_q, state_d;
  logic [1:0]          mode_q, freq_q;
  logic [4:0]          band_q;
  logic [IDX_BITS-1:0] acc_q;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic                error_q;
  logic [4:0]          idx_q;
  logic [IDX_BITS-1:0] start_q;
  logic [7:0]          width_q;
  logic                last_q;

  logic                start_legal;
  logic                data_vld;
  logic [IDX_BITS:0]   sum_w;
  logic                ovf;

  // A start is legal only when neither mode nor freq carries the illegal code.
  assign start_legal = (sfb_mode_e'(mode) != MODE_ILLEGAL) && (freq != FREQ_ILLEGAL);

  // The ROM answer arrives on the last WAIT cycle.
  assign data_vld = (state_q == ST_WAIT) && (lat_cnt_q == LAT_W'(ROM_LAT - 1));

  // One extra bit catches the sample-offset accumulator running past its range.
  assign sum_w = {1'b0, acc_q} + {{(IDX_BITS - 7){1'b0}}, width_q};
  assign ovf   = sum_w[IDX_BITS];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start && start_legal) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT:  if (data_vld) state_d = ST_EMIT;
        ST_EMIT: begin
          if (sfb_ready) begin
            if (ovf)         state_d = ST_IDLE;
            else if (last_q) state_d = ST_DONE;
            else             state_d = ST_FETCH;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: latched request, band counter, accumulator, payload and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= '0;
      freq_q    <= '0;
      band_q    <= '0;
      acc_q     <= '0;
      lat_cnt_q <= '0;
      error_q   <= 1'b0;
      idx_q     <= '0;
      start_q   <= '0;
      width_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (abort) begin
        // Any in-flight ROM response is dropped by leaving WAIT.
        lat_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              mode_q <= mode;
              freq_q <= freq;
              if (!start_legal) begin
                error_q <= 1'b1;
              end else begin
                acc_q  <= '0;
                band_q <= '0;
              end
            end
          end
          ST_FETCH: lat_cnt_q <= '0;
          ST_WAIT: begin
            if (data_vld) begin
              width_q <= rom_data;
              start_q <= acc_q;
              idx_q   <= band_q;
              last_q  <= (band_q == last_band(mode_q));
            end else begin
              lat_cnt_q <= lat_cnt_q + LAT_W'(1);
            end
          end
          ST_EMIT: begin
            if (sfb_ready) begin
              if (ovf) begin
                error_q <= 1'b1;
              end else begin
                acc_q <= sum_w[IDX_BITS-1:0];
                if (!last_q) band_q <= band_q + 5'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs decoded from the current state plus registered payload.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rom_en    = 1'b0;
    rom_addr  = '0;
    sfb_valid = 1'b0;
    case (state_q)
      ST_FETCH: begin
        busy     = 1'b1;
        rom_en   = 1'b1;
        rom_addr = {mode_q, freq_q, band_q};
      end
      ST_WAIT:  busy = 1'b1;
      ST_EMIT: begin
        busy      = 1'b1;
        sfb_valid = 1'b1;
      end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign error     = error_q;
  assign sfb_index = idx_q;
  assign sfb_start = start_q;
  assign sfb_width = width_q;
  assign sfb_last  = last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sfb_boundary_sequencer.sv
// Bench for sfb_boundary_sequencer: ROM model beside the DUT, random consumer
// backpressure, and a reference that derives records from the ROM contents
// by prefix sums.
module tb_sfb_boundary_sequencer;
  import sfb_pkg::*;

  localparam int ROM_LAT  = 1;
  localparam int IDX_BITS = 10;
  localparam int REC_W    = 24;  // {index[4:0], start[9:0], width[7:0], last}

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [1:0]          mode;
  logic [1:0]          freq;
  logic                abort;
  logic                busy;
  logic                done;
  logic                error;
  logic                rom_en;
  logic [8:0]          rom_addr;
  logic [7:0]          rom_data;
  logic                sfb_valid;
  logic                sfb_ready;
  logic [4:0]          sfb_index;
  logic [IDX_BITS-1:0] sfb_start;
  logic [7:0]          sfb_width;
  logic                sfb_last;
  sfb_state_e          dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rom_en_cnt, done_cnt, err_cnt, fetch_idx;
  int last_hs_cyc, done_cyc;
  int ready_pct;
  logic [1:0] cur_mode, cur_freq;
  logic [7:0] rom_mem [0:511];
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got_q[$];
  logic             prev_valid, prev_ready;
  logic [REC_W-1:0] prev_payload;

  int long_w [22] = '{4,4,4,4,4,4,6,6,8,8,10,12,16,20,24,28,34,42,50,54,76,158};
  int short_w[13] = '{4,4,4,4,6,8,10,12,14,18,22,30,56};

  sfb_boundary_sequencer #(.ROM_LAT(ROM_LAT), .IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .freq(freq),
    .abort(abort), .busy(busy), .done(done), .error(error),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .sfb_valid(sfb_valid), .sfb_ready(sfb_ready), .sfb_index(sfb_index),
    .sfb_start(sfb_start), .sfb_width(sfb_width), .sfb_last(sfb_last),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Width ROM with one cycle of read latency
  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  // Consumer ready with a programmable duty
  always @(posedge clk) begin
    #1;
    sfb_ready = ($urandom_range(0, 99) < ready_pct);
  end

  function automatic logic [REC_W-1:0] pack_rec(input int idx, input int st, input int w, input bit lst);
    logic [REC_W-1:0] r;
    r = {5'(idx), 10'(st), 8'(w), lst};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: collects transfers, counts pulses, checks fetch addresses and hold rules
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready && !abort) begin
        check("hold_valid", sfb_valid, 1);
        check("hold_payload", {sfb_index, sfb_start, sfb_width, sfb_last}, prev_payload);
      end
      if (sfb_valid && sfb_ready) begin
        got_q.push_back({sfb_index, sfb_start, sfb_width, sfb_last});
        last_hs_cyc = cyc;
      end
      if (rom_en) begin
        check("rom_addr", rom_addr, {cur_mode, cur_freq, 5'(fetch_idx)});
        rom_en_cnt++;
        fetch_idx++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (error) err_cnt++;
      prev_valid   = sfb_valid;
      prev_ready   = sfb_ready;
      prev_payload = {sfb_index, sfb_start, sfb_width, sfb_last};
    end
  end

  // Reference: band count from the mode, starts as running sums of ROM widths,
  // stopping at the first transfer that would leave the 10-bit range.
  task automatic build_exp(input logic [1:0] m, input logic [1:0] f, output bit ovf);
    int n, acc, w;
    n = (m == 2'b01) ? 13 : (m == 2'b10) ? 17 : 22;
    acc = 0;
    ovf = 1'b0;
    exp_q.delete();
    for (int b = 0; b < n; b++) begin
      w = int'(rom_mem[{m, f, 5'(b)}]);
      exp_q.push_back(pack_rec(b, acc, w, b == n - 1));
      if (acc + w > 1023) begin
        ovf = 1'b1;
        break;
      end
      acc += w;
    end
  endtask

  task automatic clear_counts(input logic [1:0] m, input logic [1:0] f);
    rom_en_cnt = 0; done_cnt = 0; err_cnt = 0; fetch_idx = 0;
    cur_mode = m; cur_freq = f;
    got_q.delete();
  endtask

  task automatic do_start(input logic [1:0] m, input logic [1:0] f);
    @(posedge clk); #1;
    start = 1'b1; mode = m; freq = f;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_granule(input logic [1:0] m, input logic [1:0] f, input int pct, input string tag);
    bit ovf;
    int n;
    build_exp(m, f, ovf);
    clear_counts(m, f);
    ready_pct = pct;
    do_start(m, f);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (sfb_valid) break;
    end
    check({tag, "_first_valid_lat"}, n, 3);
    for (int i = 0; i < 3000 && done_cnt == 0 && err_cnt == 0; i++) @(negedge clk);
    check({tag, "_completed"}, (done_cnt + err_cnt) != 0, 1);
    repeat (3) @(negedge clk);
    check({tag, "_rec_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check({tag, "_rec"}, got_q[i], exp_q[i]);
    check({tag, "_rom_en_cnt"}, rom_en_cnt, exp_q.size());
    check({tag, "_done_cnt"}, done_cnt, ovf ? 0 : 1);
    check({tag, "_err_cnt"}, err_cnt, ovf ? 1 : 0);
    check({tag, "_busy_end"}, busy, 0);
    if (!ovf) check({tag, "_done_lat"}, done_cyc - last_hs_cyc, 1);
  endtask

  task automatic illegal_start(input logic [1:0] m, input logic [1:0] f, input string tag);
    clear_counts(m, f);
    do_start(m, f);
    @(negedge clk);
    check({tag, "_err_pulse"}, error, 1);
    check({tag, "_busy"}, busy, 0);
    @(negedge clk);
    check({tag, "_err_drop"}, error, 0);
    repeat (4) @(negedge clk);
    check({tag, "_rom_en_cnt"}, rom_en_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 1);
  endtask

  initial begin
    bit found;
    logic [1:0] rm, rf;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; freq = 2'b00;
    sfb_ready = 1'b0; rom_data = 8'd0; ready_pct = 100;
    cur_mode = 2'b00; cur_freq = 2'b00;
    for (int a = 0; a < 512; a++) rom_mem[a] = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_valid", sfb_valid, 0);
    check("rst_payload", {sfb_index, sfb_start, sfb_width, sfb_last}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;

    // Long 44.1k, ready held high
    for (int b = 0; b < 22; b++) rom_mem[{2'b00, 2'b00, 5'(b)}] = 8'(long_w[b]);
    run_granule(2'b00, 2'b00, 100, "long");
    if (got_q.size() == 22) begin
      check("long_b21_start", got_q[21][18:9], 418);
      check("long_b21_width", got_q[21][8:1], 158);
      check("long_b21_last", got_q[21][0], 1);
    end

    // Short 44.1k
    for (int b = 0; b < 13; b++) rom_mem[{2'b01, 2'b00, 5'(b)}] = 8'(short_w[b]);
    run_granule(2'b01, 2'b00, 100, "short");
    if (got_q.size() == 13) check("short_b12_start", got_q[12][18:9], 136);

    // Long case under random backpressure
    run_granule(2'b00, 2'b00, 45, "long_bp");

    // Illegal mode, then illegal freq
    illegal_start(2'b11, 2'b00, "ill_mode");
    illegal_start(2'b00, 2'b11, "ill_freq");

    // Abort while band 5 is on offer
    clear_counts(2'b00, 2'b00);
    ready_pct = 100;
    do_start(2'b00, 2'b00);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sfb_valid && sfb_index == 5'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_b5", found, 1);
    abort = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", sfb_valid, 0);
    check("abort_rom_en", rom_en, 0);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_err", err_cnt, 0);
    run_granule(2'b00, 2'b00, 100, "restart");

    // Accumulator overflow with every width at 255
    for (int b = 0; b < 22; b++) rom_mem[{2'b00, 2'b01, 5'(b)}] = 8'd255;
    run_granule(2'b00, 2'b01, 100, "ovf");

    // Randomized legal granules under random backpressure
    for (int k = 0; k < 3; k++) begin
      rm = 2'($urandom_range(0, 2));
      rf = 2'($urandom_range(0, 2));
      for (int b = 0; b < 22; b++) rom_mem[{rm, rf, 5'(b)}] = 8'($urandom_range(1, 40));
      run_granule(rm, rf, $urandom_range(30, 90), "rand");
    end

    // Reset in the middle of a sequence
    ready_pct = 100;
    clear_counts(2'b10, 2'b10);
    do_start(2'b10, 2'b10);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", sfb_valid, 0);
    check("mid_rst_rom_en", rom_en, 0);
    check("mid_rst_payload", {sfb_index, sfb_start, sfb_width, sfb_last}, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    run_granule(2'b01, 2'b00, 100, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
